// File: rtl/pole_controller.sv
// Lever/pole sequencer: arbitrates player pushes against the pole box and steps
// LEFT -> TO_RIGHT -> RIGHT -> TO_LEFT, advancing only on frame_tick.
module pole_controller #(
   parameter int unsigned POLE_X         = 140,
   parameter int unsigned POLE_Y         = 310,
   parameter int unsigned POLE_SIZE      = 24,
   parameter int unsigned PLAYER_SIZE    = 32,
   parameter int unsigned HOLD_FRAMES    = 8,
   parameter int unsigned TRANSIT_FRAMES = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [9:0] fire_x,
   input  logic [9:0] fire_y,
   input  logic       fire_left,
   input  logic       fire_right,
   input  logic [9:0] water_x,
   input  logic [9:0] water_y,
   input  logic       water_left,
   input  logic       water_right,
   output logic [1:0] sprite_sel,
   output logic       lever_on,
   output logic       toggle_pulse,
   output logic [7:0] push_count
);

   localparam logic [10:0] X_LO  = 11'(POLE_X);
   localparam logic [10:0] X_HI  = 11'(POLE_X + POLE_SIZE);
   localparam logic [10:0] Y_LO  = 11'(POLE_Y);
   localparam logic [10:0] Y_HI  = 11'(POLE_Y + POLE_SIZE);
   localparam logic [10:0] P_SZ  = 11'(PLAYER_SIZE);
   localparam logic [8:0]  HOLD  = 9'(HOLD_FRAMES);
   localparam logic [7:0]  T_END = 8'(TRANSIT_FRAMES - 1);

   typedef enum logic [1:0] {StLeft, StToRight, StRight, StToLeft} state_e;

   state_e     r_state, w_state_d;
   logic [7:0] r_push_count, w_push_count_d;
   logic [7:0] r_transit, w_transit_d;
   logic       r_toggle, w_toggle_d;
   logic [1:0] r_sprite_sel, w_sprite_sel_d;
   logic       r_lever_on, w_lever_on_d;

   logic w_fire_touch, w_water_touch;
   logic w_push_r, w_push_l, w_net_r, w_net_l, w_net_dir, w_count_full;

   // 11-bit compare so px + PLAYER_SIZE cannot wrap.
   function automatic logic touching(input logic [9:0] px, input logic [9:0] py);
      logic [10:0] w_px, w_py;
      w_px = {1'b0, px};
      w_py = {1'b0, py};
      return (w_px < X_HI) && ((w_px + P_SZ) > X_LO) &&
             (w_py < Y_HI) && ((w_py + P_SZ) > Y_LO);
   endfunction

   assign w_fire_touch  = touching(fire_x, fire_y);
   assign w_water_touch = touching(water_x, water_y);

   assign w_push_r = (w_fire_touch & fire_right & ~fire_left) |
                     (w_water_touch & water_right & ~water_left);
   assign w_push_l = (w_fire_touch & fire_left & ~fire_right) |
                     (w_water_touch & water_left & ~water_right);
   assign w_net_r  = w_push_r & ~w_push_l;
   assign w_net_l  = w_push_l & ~w_push_r;

   // Counting direction depends on which rest state we are in.
   assign w_net_dir    = (r_state == StLeft) ? w_net_r : w_net_l;
   assign w_count_full = (r_push_count == 8'hFF);

   always_comb begin
      w_state_d      = r_state;
      w_push_count_d = r_push_count;
      w_transit_d    = r_transit;
      w_toggle_d     = 1'b0;
      if (frame_tick) begin
         unique case (r_state)
            StLeft, StRight: begin
               if (!w_net_dir) begin
                  w_push_count_d = 8'd0;
               end else if (({1'b0, r_push_count} + 9'd1) == HOLD) begin
                  w_state_d      = (r_state == StLeft) ? StToRight : StToLeft;
                  w_push_count_d = 8'd0;
                  w_transit_d    = 8'd0;
               end else if (!w_count_full) begin
                  w_push_count_d = r_push_count + 8'd1;
               end
            end
            StToRight, StToLeft: begin
               if (r_transit == T_END) begin
                  w_state_d   = (r_state == StToRight) ? StRight : StLeft;
                  w_transit_d = 8'd0;
                  w_toggle_d  = 1'b1;
               end else begin
                  w_transit_d = r_transit + 8'd1;
               end
            end
            default: w_state_d = StLeft;
         endcase
      end
   end

   always_comb begin
      w_sprite_sel_d = 2'd0;
      w_lever_on_d   = 1'b0;
      unique case (w_state_d)
         StLeft:    begin w_sprite_sel_d = 2'd0; w_lever_on_d = 1'b0; end
         StToRight: begin w_sprite_sel_d = 2'd1; w_lever_on_d = 1'b0; end
         StRight:   begin w_sprite_sel_d = 2'd2; w_lever_on_d = 1'b1; end
         StToLeft:  begin w_sprite_sel_d = 2'd1; w_lever_on_d = 1'b1; end
         default:   begin w_sprite_sel_d = 2'd0; w_lever_on_d = 1'b0; end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state      <= StLeft;
         r_push_count <= 8'd0;
         r_transit    <= 8'd0;
         r_toggle     <= 1'b0;
         r_sprite_sel <= 2'd0;
         r_lever_on   <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_push_count <= w_push_count_d;
         r_transit    <= w_transit_d;
         r_toggle     <= w_toggle_d;
         r_sprite_sel <= w_sprite_sel_d;
         r_lever_on   <= w_lever_on_d;
      end
   end

   assign sprite_sel   = r_sprite_sel;
   assign lever_on     = r_lever_on;
   assign toggle_pulse = r_toggle;
   assign push_count   = r_push_count;

endmodule

// File: tb/tb_pole_controller.sv
// Directed bench for pole_controller: frame-level lever model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_pole_controller;

   localparam int PX = 140, PY = 310, PS = 24, PL = 32;
   localparam int HOLD = 8, TRANSIT = 4;

   logic       Clk = 1'b0;
   logic       Reset, frame_tick;
   logic [9:0] fire_x, fire_y, water_x, water_y;
   logic       fire_left, fire_right, water_left, water_right;
   logic [1:0] sprite_sel;
   logic       lever_on, toggle_pulse;
   logic [7:0] push_count;

   pole_controller dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_tick  (frame_tick),
      .fire_x      (fire_x),
      .fire_y      (fire_y),
      .fire_left   (fire_left),
      .fire_right  (fire_right),
      .water_x     (water_x),
      .water_y     (water_y),
      .water_left  (water_left),
      .water_right (water_right),
      .sprite_sel  (sprite_sel),
      .lever_on    (lever_on),
      .toggle_pulse(toggle_pulse),
      .push_count  (push_count)
   );

   always #5 Clk = ~Clk;

   int total = 0, bad = 0, pulses = 0;
   bit cmp_en = 0;
   logic s_pulse, s_lever;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: which side the lever rests on, whether it is
   // swinging, how many consecutive useful push frames, frames spent swinging.
   bit m_right = 0, m_mid = 0, m_pulse = 0;
   int m_hold = 0, m_mid_frames = 0;

   function automatic bit touch(input int x, input int y);
      return (x < PX + PS) && (x + PL > PX) && (y < PY + PS) && (y + PL > PY);
   endfunction

   bit m_pr, m_pl;
   int m_req;
   assign m_pr = (touch(fire_x, fire_y) && fire_right && !fire_left) ||
                 (touch(water_x, water_y) && water_right && !water_left);
   assign m_pl = (touch(fire_x, fire_y) && fire_left && !fire_right) ||
                 (touch(water_x, water_y) && water_left && !water_right);
   assign m_req = (m_pr && !m_pl) ? 1 : ((m_pl && !m_pr) ? -1 : 0);

   always @(posedge Clk) begin
      m_pulse <= 0;
      if (Reset) begin
         m_right <= 0; m_mid <= 0; m_hold <= 0; m_mid_frames <= 0;
      end else if (frame_tick) begin
         if (m_mid) begin
            if (m_mid_frames + 1 == TRANSIT) begin
               m_mid <= 0; m_right <= !m_right; m_pulse <= 1; m_mid_frames <= 0;
            end else begin
               m_mid_frames <= m_mid_frames + 1;
            end
         end else if (m_req == (m_right ? -1 : 1)) begin
            if (m_hold + 1 >= HOLD) begin
               m_mid <= 1; m_hold <= 0; m_mid_frames <= 0;
            end else begin
               m_hold <= (m_hold + 1 > 255) ? 255 : m_hold + 1;
            end
         end else begin
            m_hold <= 0;
         end
      end
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         check("sprite_sel", sprite_sel, m_mid ? 1 : (m_right ? 2 : 0));
         check("lever_on", lever_on, m_right);
         check("toggle_pulse", toggle_pulse, m_pulse);
         check("push_count", push_count, m_hold);
         if (toggle_pulse === 1'b1) pulses++;
      end
   end

   // One frame: tick for one cycle, then an idle cycle; samples the cycle
   // right after the tick edge.
   task automatic do_tick();
      frame_tick = 1'b1;
      @(negedge Clk);
      s_pulse = toggle_pulse;
      s_lever = lever_on;
      frame_tick = 1'b0;
      @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   int p0;

   initial begin
      Reset = 1'b1; frame_tick = 1'b0;
      fire_x = 10'd0; fire_y = 10'd0; fire_left = 1'b0; fire_right = 1'b0;
      water_x = 10'd600; water_y = 10'd400; water_left = 1'b0; water_right = 1'b0;
      repeat (2) @(negedge Clk);
      cmp_en = 1;
      check("rst_sprite", sprite_sel, 0);
      check("rst_lever", lever_on, 0);
      check("rst_toggle", toggle_pulse, 0);
      check("rst_count", push_count, 0);
      Reset = 1'b0;

      // Idle frames
      repeat (3) do_tick();
      check("idle_sprite", sprite_sel, 0);
      check("idle_pulses", pulses, 0);

      // Fire pushes right for 8 frames, then 4 transit frames
      fire_x = 10'd130; fire_y = 10'd300; fire_right = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         do_tick();
         check("push_run", push_count, i);
      end
      do_tick();
      check("flip_start_sprite", sprite_sel, 1);
      check("flip_start_lever", lever_on, 0);
      repeat (3) do_tick();
      check("transit_sprite", sprite_sel, 1);
      do_tick();
      check("right_pulse", s_pulse, 1);
      check("right_lever_with_pulse", s_lever, 1);
      check("right_sprite", sprite_sel, 2);
      check("right_pulses", pulses, 1);

      // Interrupted push run
      do_reset();
      repeat (5) do_tick();
      check("run5_count", push_count, 5);
      fire_right = 1'b0;
      do_tick();
      check("release_clear", push_count, 0);
      fire_right = 1'b1;
      repeat (7) do_tick();
      check("run2_pre_sprite", sprite_sel, 0);
      check("run2_pre_count", push_count, 7);
      do_tick();
      check("run2_flip", sprite_sel, 1);

      // Opposing pushes cancel; same-direction pushes count once
      do_reset();
      water_x = 10'd130; water_y = 10'd300; water_left = 1'b1;
      repeat (20) do_tick();
      check("oppose_count", push_count, 0);
      check("oppose_sprite", sprite_sel, 0);
      water_left = 1'b0; water_right = 1'b1;
      repeat (7) do_tick();
      check("both_pre_sprite", sprite_sel, 0);
      check("both_pre_count", push_count, 7);
      do_tick();
      check("both_flip", sprite_sel, 1);
      repeat (4) do_tick();
      check("both_right", sprite_sel, 2);

      // In RIGHT: out-of-contact push ignored, in-contact push flips back
      fire_x = 10'd0; fire_y = 10'd0; fire_right = 1'b0;
      water_x = 10'd170; water_y = 10'd310; water_right = 1'b0; water_left = 1'b1;
      repeat (10) do_tick();
      check("nocontact_sprite", sprite_sel, 2);
      check("nocontact_count", push_count, 0);
      water_x = 10'd150;
      repeat (7) do_tick();
      check("left_pre_count", push_count, 7);
      do_tick();
      check("toleft_sprite", sprite_sel, 1);
      check("toleft_lever", lever_on, 1);
      p0 = pulses;
      repeat (3) do_tick();
      check("toleft_lever_hold", lever_on, 1);
      do_tick();
      check("left_pulse", s_pulse, 1);
      check("left_lever_with_pulse", s_lever, 0);
      check("left_sprite", sprite_sel, 0);
      check("left_pulses", pulses, p0 + 1);

      // Reset in mid-transit, coinciding with a tick; then held tick pushes
      water_left = 1'b0; water_x = 10'd600; water_y = 10'd400;
      fire_x = 10'd130; fire_y = 10'd300; fire_right = 1'b1;
      repeat (8) do_tick();
      repeat (2) do_tick();
      check("pre_reset_sprite", sprite_sel, 1);
      p0 = pulses;
      Reset = 1'b1; frame_tick = 1'b1;
      @(negedge Clk);
      check("midreset_sprite", sprite_sel, 0);
      check("midreset_lever", lever_on, 0);
      check("midreset_toggle", toggle_pulse, 0);
      Reset = 1'b0;
      repeat (8) @(negedge Clk);
      frame_tick = 1'b0;
      check("held_tick_flip", sprite_sel, 1);
      repeat (4) do_tick();
      check("after_reset_right", sprite_sel, 2);
      check("after_reset_pulses", pulses, p0 + 1);

      repeat (2) @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
